cell_segmenter: RTL and testbench

Ingress segmentation stage directly upstream of the switch core. Accepts one frame at a time as 128-bit words with a 4-bit destination port map. Cuts each frame into 64-byte cells of four words, zero-padding the last cell. Writes the words into the core's cell data FIFO, then writes one 16-bit pointer descriptor per frame into the core's pointer FIFO, and honours the core's backpressure.

---
 rtl/cell_pkg.sv | 33 +++
 rtl/cell_seg_stats.sv | 28 ++
 rtl/cell_segmenter.sv | 160 ++++++++++++++++
 tb/tb_cell_segmenter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// Shared definitions for the cell segmenter.
//   CELL_WORDS / MAX_CELLS : cell geometry and the per-frame cell limit
//   DESC_*                 : bit positions of the 16-bit pointer descriptor
//   seg_state_t            : segmenter FSM states
//   make_desc()            : packs portmap and cell count into a descriptor
package cell_pkg;

  localparam int CELL_WORDS   = 4;
  localparam int MAX_CELLS    = 63;

  localparam int DESC_PM_LSB  = 8;
  localparam int DESC_PM_MSB  = 11;
  localparam int DESC_CNT_LSB = 0;
  localparam int DESC_CNT_MSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_PAD  = 3'd2,
    ST_PTR  = 3'd3,
    ST_DROP = 3'd4
  } seg_state_t;

  // Unused descriptor bits stay zero.
  function automatic logic [15:0] make_desc(input logic [3:0] pm, input logic [5:0] cnt);
    logic [15:0] d;
    d = '0;
    d[DESC_PM_MSB:DESC_PM_LSB]   = pm;
    d[DESC_CNT_MSB:DESC_CNT_LSB] = cnt;
    return d;
  endfunction

endpackage

// File: rtl/cell_seg_stats.sv
// Saturating statistics counters for the cell segmenter.
//   clk, rst    : clock, asynchronous active-high reset
//   frame_inc   : one-cycle pulse per descriptor written
//   drop_inc    : one-cycle pulse per dropped frame
//   stat_frames : descriptors written, saturates at all-ones
//   stat_drops  : frames dropped, saturates at all-ones
module cell_seg_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_inc,
  input  logic        drop_inc,
  output logic [31:0] stat_frames,
  output logic [15:0] stat_drops
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      if (frame_inc && (stat_frames != '1))
        stat_frames <= stat_frames + 32'd1;
      if (drop_inc && (stat_drops != '1))
        stat_drops <= stat_drops + 16'd1;
    end
  end

endmodule

// File: rtl/cell_segmenter.sv
// Ingress segmentation stage in front of the switch core.
// Cuts frames of 128-bit words into 4-word cells (last cell zero-padded),
// writes the words to the core's cell data FIFO and then one descriptor
// per frame to the core's pointer FIFO.
//   clk, rst              : clock, asynchronous active-high reset
//   s_*                   : frame input with valid/ready handshake
//   i_cell_data_fifo_*    : cell word output to the core (registered)
//   i_cell_ptr_fifo_*     : descriptor output to the core (registered)
//   i_cell_bp             : core backpressure, honoured at cell boundaries
//   seg_err               : pulse on truncation or missing end-of-frame
// Optional build macro CELL_SEGMENTER_STATS_EN adds stat_frames and
// stat_drops counter outputs.
module cell_segmenter
  import cell_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_data,
  input  logic         s_valid,
  input  logic         s_sop,
  input  logic         s_eop,
  input  logic [3:0]   s_portmap,
  output logic         s_ready,
  output logic [127:0] i_cell_data_fifo_din,
  output logic         i_cell_data_fifo_wr,
  output logic [15:0]  i_cell_ptr_fifo_din,
  output logic         i_cell_ptr_fifo_wr,
  input  logic         i_cell_bp,
`ifdef CELL_SEGMENTER_STATS_EN
  output logic [31:0]  stat_frames,
  output logic [15:0]  stat_drops,
`endif
  output logic         seg_err
);

  seg_state_t  state;
  logic [1:0]  word_idx;
  logic [5:0]  cell_cnt;
  logic [3:0]  portmap;
  logic        truncated;
  logic        drop_after;  // after this descriptor, swallow the frame that cut us short
  logic        active;      // holds s_ready low in the first cycle out of reset
  logic        accept;
  logic [1:0]  next_idx;
  logic        last_word;   // this word completes a cell

  assign accept    = s_valid && s_ready;
  assign next_idx  = word_idx + 2'd1;
  assign last_word = (word_idx == 2'(CELL_WORDS - 1));

  // A started cell always completes: backpressure only gates the first word of a cell.
  always_comb begin
    s_ready = 1'b0;
    if (active) begin
      case (state)
        ST_IDLE: s_ready = !i_cell_bp;
        ST_DATA: s_ready = !((word_idx == 2'd0) && i_cell_bp);
        ST_DROP: s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      word_idx             <= '0;
      cell_cnt             <= '0;
      portmap              <= '0;
      truncated            <= 1'b0;
      drop_after           <= 1'b0;
      active               <= 1'b0;
      i_cell_data_fifo_din <= '0;
      i_cell_data_fifo_wr  <= 1'b0;
      i_cell_ptr_fifo_din  <= '0;
      i_cell_ptr_fifo_wr   <= 1'b0;
      seg_err              <= 1'b0;
    end else begin
      active              <= 1'b1;
      i_cell_data_fifo_wr <= 1'b0;
      i_cell_ptr_fifo_wr  <= 1'b0;
      seg_err             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && s_sop) begin
            truncated  <= 1'b0;
            drop_after <= 1'b0;
            if (s_portmap == 4'd0) begin
              if (!s_eop) state <= ST_DROP;
            end else begin
              portmap              <= s_portmap;
              i_cell_data_fifo_din <= s_data;
              i_cell_data_fifo_wr  <= 1'b1;
              word_idx             <= 2'd1;
              cell_cnt             <= 6'd1;
              state                <= s_eop ? ST_PAD : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            if (s_sop) begin
              // Missing eop: close this frame, then discard the new one.
              seg_err    <= 1'b1;
              truncated  <= 1'b0;
              drop_after <= !s_eop;
              state      <= (word_idx != 2'd0) ? ST_PAD : ST_PTR;
            end else if ((word_idx == 2'd0) && (cell_cnt == 6'(MAX_CELLS))) begin
              // This word would open a cell the descriptor cannot count.
              seg_err   <= 1'b1;
              truncated <= 1'b1;
              state     <= s_eop ? ST_PTR : ST_DROP;
            end else begin
              i_cell_data_fifo_din <= s_data;
              i_cell_data_fifo_wr  <= 1'b1;
              word_idx             <= next_idx;
              if (word_idx == 2'd0) cell_cnt <= cell_cnt + 6'd1;
              if (s_eop) state <= (next_idx != 2'd0) ? ST_PAD : ST_PTR;
            end
          end
        end
        ST_PAD: begin
          i_cell_data_fifo_din <= '0;
          i_cell_data_fifo_wr  <= 1'b1;
          word_idx             <= next_idx;
          if (last_word) state <= ST_PTR;
        end
        ST_PTR: begin
          i_cell_ptr_fifo_din <= make_desc(portmap, cell_cnt);
          i_cell_ptr_fifo_wr  <= 1'b1;
          truncated           <= 1'b0;
          drop_after          <= 1'b0;
          state               <= drop_after ? ST_DROP : ST_IDLE;
        end
        ST_DROP: begin
          if (accept && s_eop) state <= truncated ? ST_PTR : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CELL_SEGMENTER_STATS_EN
  logic drop_evt;
  assign drop_evt = accept && s_sop &&
                    (((state == ST_IDLE) && (s_portmap == 4'd0)) || (state == ST_DATA));

  cell_seg_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .frame_inc   (i_cell_ptr_fifo_wr),
    .drop_inc    (drop_evt),
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops)
  );
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_cell_segmenter.sv
module tb_cell_segmenter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_sop = 1'b0;
  logic         s_eop = 1'b0;
  logic [3:0]   s_portmap = '0;
  logic         s_ready;
  logic [127:0] i_cell_data_fifo_din;
  logic         i_cell_data_fifo_wr;
  logic [15:0]  i_cell_ptr_fifo_din;
  logic         i_cell_ptr_fifo_wr;
  logic         i_cell_bp = 1'b0;
  logic         seg_err;
`ifdef CELL_SEGMENTER_STATS_EN
  logic [31:0]  stat_frames;
  logic [15:0]  stat_drops;
`endif

  cell_segmenter dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_sop                (s_sop),
    .s_eop                (s_eop),
    .s_portmap            (s_portmap),
    .s_ready              (s_ready),
    .i_cell_data_fifo_din (i_cell_data_fifo_din),
    .i_cell_data_fifo_wr  (i_cell_data_fifo_wr),
    .i_cell_ptr_fifo_din  (i_cell_ptr_fifo_din),
    .i_cell_ptr_fifo_wr   (i_cell_ptr_fifo_wr),
    .i_cell_bp            (i_cell_bp),
`ifdef CELL_SEGMENTER_STATS_EN
    .stat_frames          (stat_frames),
    .stat_drops           (stat_drops),
`endif
    .seg_err              (seg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_data_q[$];
  logic [15:0]  exp_ptr_q[$];
  int data_wr_cnt = 0;
  int ptr_wr_cnt  = 0;
  int seg_err_cnt = 0;
  int exp_seg_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop and compare every write the DUT makes.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_cell_data_fifo_wr) begin
        data_wr_cnt++;
        if (exp_data_q.size() == 0)
          check_val("data_unexpected_wr", {127'd0, i_cell_data_fifo_wr}, 128'd0);
        else
          check_val("data_word", i_cell_data_fifo_din, exp_data_q.pop_front());
      end
      if (i_cell_ptr_fifo_wr) begin
        ptr_wr_cnt++;
        $display("desc write %h", i_cell_ptr_fifo_din);
        if (exp_ptr_q.size() == 0)
          check_val("ptr_unexpected_wr", {127'd0, i_cell_ptr_fifo_wr}, 128'd0);
        else
          check_val("descriptor", {112'd0, i_cell_ptr_fifo_din}, {112'd0, exp_ptr_q.pop_front()});
      end
      if (seg_err) seg_err_cnt++;
    end
  end

  // mode: 0 = written normally, 1 = frame expected to be dropped, 2 = aborted by reset
  task automatic send_frame(input string name, input int n, input logic [3:0] pm,
                            input bit has_eop, input int mode,
                            input int bp_at, input int bp_len);
    logic [127:0] w;
    bit acc;
    int tries;
    int written;
    int cells;
    logic [5:0] c6;
    $display("frame %s words=%0d portmap=%b eop=%0d", name, n, pm, has_eop);
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      if (pm != 4'd0 && mode != 1 && i < 252) exp_data_q.push_back(w);
      if (i == bp_at) i_cell_bp = 1'b1;
      s_valid   = 1'b1;
      s_data    = w;
      s_sop     = (i == 0);
      s_eop     = has_eop && (i == n - 1);
      s_portmap = pm;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        @(negedge clk);
        acc = s_ready;
        tries++;
        if (pm == 4'd0 && i > 0) check_val("drop_ready", {127'd0, s_ready}, 128'd1);
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check_val("handshake_timeout", 128'd0, 128'd1);
        s_valid = 1'b0;
        return;
      end
      if (i == bp_at && bp_len > 0) begin
        s_valid = 1'b0;
        repeat (bp_len) begin
          @(negedge clk);
          check_val("bp_ready_low", {127'd0, s_ready}, 128'd0);
        end
        @(posedge clk);
        #1;
        i_cell_bp = 1'b0;
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    if (pm != 4'd0 && mode == 0) begin
      written = (n > 252) ? 252 : n;
      if (n > 252) exp_seg_err++;
      for (int k = 0; k < (4 - written % 4) % 4; k++) exp_data_q.push_back(128'd0);
      cells = (written + 3) / 4;
      c6 = 6'(cells);
      exp_ptr_q.push_back({4'b0000, pm, 2'b00, c6});
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_data_q.size() != 0 || exp_ptr_q.size() != 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    check_val({tag, "_drain"}, 128'(exp_data_q.size() + exp_ptr_q.size()), 128'd0);
  endtask

  int d0;
  int p0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_ready", {127'd0, s_ready}, 128'd0);
    check_val("rst_data_wr", {127'd0, i_cell_data_fifo_wr}, 128'd0);
    check_val("rst_ptr_wr", {127'd0, i_cell_ptr_fifo_wr}, 128'd0);
    check_val("rst_data_din", i_cell_data_fifo_din, 128'd0);
    check_val("rst_ptr_din", {112'd0, i_cell_ptr_fifo_din}, 128'd0);
    check_val("rst_seg_err", {127'd0, seg_err}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single-word frame: one word plus three pad words, descriptor 0501
    send_frame("single", 1, 4'b0101, 1'b1, 0, -1, 0);
    check_val("single_desc_model", {112'd0, exp_ptr_q[exp_ptr_q.size()-1]}, 128'h0501);
    wait_drain("single");

    // Exact two cells, no padding
    d0 = data_wr_cnt; p0 = ptr_wr_cnt;
    send_frame("eight", 8, 4'b1000, 1'b1, 0, -1, 0);
    wait_drain("eight");
    check_val("eight_writes", 128'(data_wr_cnt - d0), 128'd8);

    // Backpressure from word 4 of a 9-word frame
    d0 = data_wr_cnt; p0 = ptr_wr_cnt;
    send_frame("bp9", 9, 4'b0011, 1'b1, 0, 3, 5);
    wait_drain("bp9");
    check_val("bp9_writes", 128'(data_wr_cnt - d0), 128'd12);
    check_val("bp9_desc_cnt", 128'(ptr_wr_cnt - p0), 128'd1);

    // Overlength frame: truncated to 63 cells
    d0 = data_wr_cnt;
    send_frame("long260", 260, 4'b0110, 1'b1, 0, -1, 0);
    wait_drain("long260");
    check_val("long_writes", 128'(data_wr_cnt - d0), 128'd252);
    check_val("long_seg_err", 128'(seg_err_cnt), 128'(exp_seg_err));

    // Portmap zero: whole frame dropped
    d0 = data_wr_cnt; p0 = ptr_wr_cnt;
    send_frame("pm0", 5, 4'b0000, 1'b1, 1, -1, 0);
    wait_drain("pm0");
    check_val("pm0_writes", 128'(data_wr_cnt - d0 + ptr_wr_cnt - p0), 128'd0);
`ifdef CELL_SEGMENTER_STATS_EN
    check_val("stat_drops_pm0", {112'd0, stat_drops}, 128'd1);
`endif

    // Missing eop: 6-word frame closed by the next sop, which is dropped
    send_frame("noeop", 6, 4'b0011, 1'b0, 0, -1, 0);
    exp_seg_err++;
    send_frame("cutter", 3, 4'b0110, 1'b1, 1, -1, 0);
    wait_drain("noeop");
    check_val("noeop_seg_err", 128'(seg_err_cnt), 128'(exp_seg_err));
`ifdef CELL_SEGMENTER_STATS_EN
    check_val("stat_drops_total", {112'd0, stat_drops}, 128'd2);
    check_val("stat_frames_total", {96'd0, stat_frames}, 128'(ptr_wr_cnt));
`endif

    // Reset in the middle of a frame
    send_frame("aborted", 3, 4'b1111, 1'b0, 2, -1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_val("midrst_s_ready", {127'd0, s_ready}, 128'd0);
    check_val("midrst_data_wr", {127'd0, i_cell_data_fifo_wr}, 128'd0);
    check_val("midrst_data_din", i_cell_data_fifo_din, 128'd0);
    check_val("midrst_ptr_wr", {127'd0, i_cell_ptr_fifo_wr}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_drain("midrst");
    p0 = ptr_wr_cnt;
    send_frame("after_rst", 5, 4'b1001, 1'b1, 0, -1, 0);
    wait_drain("after_rst");
    check_val("after_rst_desc_cnt", 128'(ptr_wr_cnt - p0), 128'd1);
    check_val("final_seg_err", 128'(seg_err_cnt), 128'(exp_seg_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
